fp_round_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined rounder for the GPU's custom float format (sign|exp|frac).

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_round_pipe_if.sv | 30 +++
 rtl/fp_round_inc.sv | 33 +++
 rtl/fp_round_pipe.sv | 115 +++++++++++
 tb/tb_fp_round_pipe.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and helpers for the custom float rounder
package fp_pkg;

   localparam int EXP_W_DEF   = 7;
   localparam int MAN_W_DEF   = 10;
   localparam int EXTRA_W_DEF = 7;

   typedef enum logic [1:0] {
      RNE = 2'b00,
      RTZ = 2'b01,
      RUP = 2'b10,
      RDN = 2'b11
   } rnd_mode_e;

   typedef struct packed {
      logic                 sign;
      logic [EXP_W_DEF-1:0] exp;
      logic [MAN_W_DEF-1:0] frac;
   } fp18_t;

   // Directed modes saturate to infinity only when rounding away from zero.
   function automatic logic rounds_to_inf(rnd_mode_e mode, logic sign);
      return (mode == RNE) || ((mode == RUP) && !sign) || ((mode == RDN) && sign);
   endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// rtl/fp_round_pipe_if.sv - input/output stream bundle of the rounding pipe
interface fp_round_pipe_if #(
   parameter int EXP_W   = 7,
   parameter int MAN_W   = 10,
   parameter int EXTRA_W = 7
) ();

   logic                     in_valid;
   logic                     in_ready;
   logic                     in_sign;
   logic [EXP_W-1:0]         in_exp;
   logic [MAN_W+EXTRA_W:0]   in_mant;
   logic [1:0]               in_mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [EXP_W+MAN_W:0]     out_val;
   logic                     out_inexact;
   logic                     out_overflow;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_mode, out_ready,
      input  in_ready, out_valid, out_val, out_inexact, out_overflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_mode, out_ready,
      output in_ready, out_valid, out_val, out_inexact, out_overflow
   );

endinterface

// File: rtl/fp_round_inc.sv
// rtl/fp_round_inc.sv - round-increment decision from guard/sticky/lsb and mode
module fp_round_inc
   import fp_pkg::*;
#(
   parameter int EXTRA_W = 7
) (
   input  logic               sign,
   input  rnd_mode_e          mode,
   input  logic               lsb,
   input  logic [EXTRA_W-1:0] extra,
   output logic               inc,
   output logic               inexact
);

   logic guard;
   logic sticky;

   assign guard   = extra[EXTRA_W-1];
   assign sticky  = |extra[EXTRA_W-2:0];
   assign inexact = guard | sticky;

   always_comb begin
      inc = 1'b0;
      case (mode)
         RNE:     inc = guard & (sticky | lsb);
         RTZ:     inc = 1'b0;
         RUP:     inc = !sign & inexact;
         RDN:     inc = sign & inexact;
         default: inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage rounder: increment/carry, then exponent fixup and saturation
module fp_round_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W   = EXP_W_DEF,
   parameter int MAN_W   = MAN_W_DEF,
   parameter int EXTRA_W = EXTRA_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   fp_round_pipe_if.slave  rp
);

   localparam int SUM_W = MAN_W + 2;
   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [SUM_W-1:0] SUM_CARRY = {1'b1, {(MAN_W+1){1'b0}}};

   logic                 advance;
   logic                 inc;
   logic                 inexact1;
   logic [SUM_W-1:0]     sum1;

   logic                 s1_valid;
   logic                 s1_sign;
   logic [EXP_W-1:0]     s1_exp;
   rnd_mode_e            s1_mode;
   logic                 s1_carry;
   logic [MAN_W-1:0]     s1_frac;
   logic                 s1_inexact;

   logic [EXP_W:0]       exp2;
   logic [EXP_W+MAN_W:0] val2;
   logic                 inx2;
   logic                 ovf2;

   logic                 out_valid_q;
   logic [EXP_W+MAN_W:0] out_val_q;
   logic                 out_inexact_q;
   logic                 out_overflow_q;

   // The whole pipe advances in lockstep, so one stall signal covers both stages.
   assign advance     = !out_valid_q || rp.out_ready;
   assign rp.in_ready = advance;

   fp_round_inc #(.EXTRA_W(EXTRA_W)) u_inc (
      .sign    (rp.in_sign),
      .mode    (rnd_mode_e'(rp.in_mode)),
      .lsb     (rp.in_mant[EXTRA_W]),
      .extra   (rp.in_mant[EXTRA_W-1:0]),
      .inc     (inc),
      .inexact (inexact1)
   );

   assign sum1 = {1'b0, rp.in_mant[MAN_W+EXTRA_W:EXTRA_W]} + {{(SUM_W-1){1'b0}}, inc};

   always_comb begin
      exp2 = {1'b0, s1_exp} + {{EXP_W{1'b0}}, s1_carry};
      val2 = {s1_sign, exp2[EXP_W-1:0], (s1_carry ? {MAN_W{1'b0}} : s1_frac)};
      inx2 = s1_inexact;
      ovf2 = 1'b0;
      if (s1_exp == '0) begin
         val2 = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
         inx2 = 1'b0;
      end else if (exp2 >= EXP_MAX) begin
         ovf2 = 1'b1;
         inx2 = 1'b1;
         if (rounds_to_inf(s1_mode, s1_sign))
            val2 = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else
            val2 = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid       <= 1'b0;
         s1_sign        <= 1'b0;
         s1_exp         <= '0;
         s1_mode        <= RNE;
         s1_carry       <= 1'b0;
         s1_frac        <= '0;
         s1_inexact     <= 1'b0;
         out_valid_q    <= 1'b0;
         out_val_q      <= '0;
         out_inexact_q  <= 1'b0;
         out_overflow_q <= 1'b0;
      end else if (advance) begin
         s1_valid    <= rp.in_valid && !flush;
         out_valid_q <= s1_valid && !flush;
         if (rp.in_valid) begin
            s1_sign    <= rp.in_sign;
            s1_exp     <= rp.in_exp;
            s1_mode    <= rnd_mode_e'(rp.in_mode);
            s1_carry   <= (sum1 == SUM_CARRY);
            s1_frac    <= sum1[MAN_W-1:0];
            s1_inexact <= inexact1;
         end
         if (s1_valid) begin
            out_val_q      <= val2;
            out_inexact_q  <= inx2;
            out_overflow_q <= ovf2;
         end
      end else if (flush) begin
         s1_valid    <= 1'b0;
         out_valid_q <= 1'b0;
      end
   end

   assign rp.out_valid    = out_valid_q;
   assign rp.out_val      = out_val_q;
   assign rp.out_inexact  = out_inexact_q;
   assign rp.out_overflow = out_overflow_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - directed vector bench for fp_round_pipe
module tb_fp_round_pipe;

   localparam logic [1:0] M_RNE = 2'b00;
   localparam logic [1:0] M_RTZ = 2'b01;
   localparam logic [1:0] M_RUP = 2'b10;
   localparam logic [1:0] M_RDN = 2'b11;

   typedef struct packed {
      logic        sign;
      logic [6:0]  exp;
      logic [17:0] mant;
      logic [1:0]  mode;
      logic [17:0] val;
      logic        inx;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   checks = 0;
   int   errors = 0;
   vec_t vq[$];

   fp_round_pipe_if #(.EXP_W(7), .MAN_W(10), .EXTRA_W(7)) bus ();

   fp_round_pipe #(.EXP_W(7), .MAN_W(10), .EXTRA_W(7)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .rp    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.in_sign = v.sign;
      bus.in_exp  = v.exp;
      bus.in_mant = v.mant;
      bus.in_mode = v.mode;
   endtask

   task automatic check_out(input vec_t v, input string name);
      logic [19:0] act;
      logic [19:0] req;
      act = {bus.out_overflow, bus.out_inexact, bus.out_val};
      req = {v.ovf, v.inx, v.val};
      check(act == req, name, 32'(act), 32'(req));
   endtask

   task automatic run_vec(input int i);
      int w;
      @(negedge clk);
      drive(vq[i]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      w = 0;
      while (!bus.out_valid && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (!bus.out_valid) begin
         check(1'b0, $sformatf("vec%0d_timeout", i), 0, 1);
      end else begin
         check_out(vq[i], $sformatf("vec%0d", i));
         if (i == 0) check(w == 1, "latency_2", 32'(w + 1), 32'd2);
      end
   endtask

   task automatic load_two_in_flight(input bit flush_now);
      @(negedge clk);
      drive(vq[0]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive(vq[1]);
      @(negedge clk);
      drive(vq[2]);
      flush = flush_now;
      check(bus.out_valid == 1'b1, "two_in_flight", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic expect_quiet(input string name);
      bit seen;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check(!seen, name, 32'(seen), 32'd0);
   endtask

   initial begin
      int sent;
      int rcv;
      bit hold_pend;
      logic [17:0] hold_val;

      //          sign  exp    mant      mode   val       inx   ovf
      vq.push_back({1'b0, 7'h40, 18'h20040, M_RNE, 18'h10000, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h40, 18'h200C0, M_RNE, 18'h10002, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h40, 18'h200C0, M_RTZ, 18'h10001, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h40, 18'h3FFFF, M_RNE, 18'h10400, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h7E, 18'h3FFFF, M_RNE, 18'h1FC00, 1'b1, 1'b1});
      vq.push_back({1'b0, 7'h7E, 18'h3FFFF, M_RTZ, 18'h1FBFF, 1'b1, 1'b0});
      vq.push_back({1'b1, 7'h40, 18'h20001, M_RUP, 18'h30000, 1'b1, 1'b0});
      vq.push_back({1'b1, 7'h40, 18'h20001, M_RDN, 18'h30001, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h40, 18'h20080, M_RUP, 18'h10001, 1'b0, 1'b0});
      vq.push_back({1'b1, 7'h00, 18'h3FFFF, M_RUP, 18'h20000, 1'b0, 1'b0});
      vq.push_back({1'b0, 7'h7F, 18'h20000, M_RTZ, 18'h1FBFF, 1'b1, 1'b1});
      vq.push_back({1'b1, 7'h7F, 18'h20000, M_RDN, 18'h3FC00, 1'b1, 1'b1});
      vq.push_back({1'b1, 7'h7E, 18'h3FFFF, M_RUP, 18'h3FBFF, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h10, 18'h3FFC0, M_RNE, 18'h04400, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h10, 18'h2803F, M_RNE, 18'h04100, 1'b1, 1'b0});
      vq.push_back({1'b0, 7'h7E, 18'h3FF81, M_RUP, 18'h1FC00, 1'b1, 1'b1});
      vq.push_back({1'b0, 7'h7F, 18'h20000, M_RDN, 18'h1FBFF, 1'b1, 1'b1});

      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      drive(vq[0]);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check(bus.out_valid == 1'b0, "reset_out_valid", 32'(bus.out_valid), 32'd0);
      check({bus.out_overflow, bus.out_inexact, bus.out_val} == 20'd0, "reset_out_val",
            32'({bus.out_overflow, bus.out_inexact, bus.out_val}), 32'd0);
      check(bus.in_ready == 1'b1, "reset_in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < vq.size(); i++) run_vec(i);

      // Backpressure stream: out_ready alternates 1,0,1,0...
      sent = 0;
      rcv = 0;
      hold_pend = 1'b0;
      hold_val = '0;
      for (int cyc = 0; cyc < 200 && rcv < 8; cyc++) begin
         @(negedge clk);
         if (hold_pend)
            check(bus.out_valid && bus.out_val == hold_val, "stall_stable", 32'(bus.out_val), 32'(hold_val));
         hold_pend = 1'b0;
         bus.in_valid = (sent < 8);
         if (sent < 8) drive(vq[sent]);
         bus.out_ready = (cyc % 2 == 0);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            check_out(vq[rcv], $sformatf("stream_beat%0d", rcv));
            rcv++;
         end else if (bus.out_valid) begin
            hold_pend = 1'b1;
            hold_val = bus.out_val;
         end
         if (bus.in_valid && bus.in_ready) sent++;
      end
      check(rcv == 8, "stream_count", 32'(rcv), 32'd8);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      expect_quiet("stream_no_dup");

      // Flush with two beats in flight and a third offered in the same cycle.
      load_two_in_flight(1'b1);
      @(negedge clk);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      check(bus.out_valid == 1'b0, "flush_clear", 32'(bus.out_valid), 32'd0);
      expect_quiet("flush_no_stale");

      // Asynchronous reset mid-flight.
      load_two_in_flight(1'b0);
      #1 rst = 1'b1;
      #1;
      check({bus.out_valid, bus.out_overflow, bus.out_inexact, bus.out_val} == 21'd0, "async_rst_outputs",
            32'({bus.out_valid, bus.out_overflow, bus.out_inexact, bus.out_val}), 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check(bus.in_ready == 1'b1, "async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      expect_quiet("rst_no_stale");

      // Pipe still works after reset recovery.
      run_vec(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
